implication_sequencer: RTL and testbench
========================================

Name: implication_sequencer

Overview:
- Controller that sequences the antecedent/consequent signal pair driving the team's implication-property checkers.
- Emits N antecedent pulses, each followed by a consequent pulse a programmable number of cycles later. Delay 0 gives the overlapping case; delay ≥1 gives the non-overlapping and delayed cases.
- Can deliberately suppress the consequent to force checker failures and produce traces.
- Sits between the test control logic (start/abort) and the property checkers.

Parameters:
- DELAY_W, 4, width of the delay field; maximum delay is 2**DELAY_W-1 cycles.
- COUNT_W, 8, width of the pair count and of pairs_sent.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a run; sampled only in IDLE.
- abort  input  1  synchronous cancel of a run in progress.
- delay  input  DELAY_W  cycles from antecedent to consequent; latched at start.
- num_pairs  input  COUNT_W  pairs to emit; latched at start.
- drop_consequent  input  1  suppress all consequent pulses this run; latched at start.
- antecedent  output  1  antecedent pulse to the checkers.
- consequent  output  1  consequent pulse to the checkers.
- busy  output  1  a run is in progress.
- done  output  1  one-cycle pulse at normal completion.
- pairs_sent  output  COUNT_W  pairs completed in the current or last run.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM = IDLE.
  - antecedent, consequent, busy, done = 0.
  - pairs_sent = 0.
  - All latched fields = 0.
- Output timing: Moore outputs, decoded from registered state only. There is no combinational path from any input to any output.
- FSM states: IDLE, ANTE, WAIT, CONS, GAP.
- IDLE:
  - start=1 and num_pairs≠0: latch delay, num_pairs and drop_consequent; clear pairs_sent; go to ANTE.
  - start=1 and num_pairs=0: stay in IDLE; pulse done in the next cycle; clear pairs_sent.
- Pair timing: let ANTE occur at cycle T. Then consequent is high at cycle T+delay, unless dropped.
- ANTE:
  - antecedent=1.
  - delay=0: consequent=1 in the same cycle (unless drop), pairs_sent increments, next state is GAP.
  - delay=1: next state is CONS.
  - delay≥2: load wait counter with delay-2; next state is WAIT.
- WAIT: both outputs 0. Counter decrements each cycle; at 0, next state is CONS. WAIT lasts delay-1 cycles.
- CONS: consequent = !drop_consequent; pairs_sent increments; next state is GAP.
- GAP:
  - Exactly one cycle with both outputs low, so consecutive pairs never overlap.
  - If pairs_sent equals the latched count: next state is IDLE and done is pulsed in the following cycle.
  - Otherwise: next state is ANTE.
- pairs_sent increments even when the consequent is dropped. It holds its value after the run until the next start.
- Run length for N pairs at delay D: N*(D+2) cycles. With start sampled at cycle 0:
  - first ANTE at cycle 1;
  - last GAP at cycle N*(D+2);
  - done=1 and busy=0 at cycle N*(D+2)+1.
- busy is high in every non-IDLE state.
- start while busy: ignored. Latched fields are not updated.
- abort (any non-IDLE state):
  - Next cycle the FSM is in IDLE with antecedent and consequent low.
  - No done pulse; pairs_sent holds.
  - abort has priority over any other transition.
  - abort in IDLE has no effect. If abort and start are both high in IDLE, start wins.
- Reset mid-run: all outputs drop to 0 immediately (asynchronously); the FSM returns to IDLE. After rst_n deasserts, no activity occurs until a new start.
- Wrap-around: num_pairs=2**COUNT_W-1 is legal; pairs_sent never wraps within a run.

Test Plan:
- delay=0, num_pairs=1, start @cycle0 -> antecedent=consequent=1 @1; GAP @2; done=1, busy=0, pairs_sent=1 @3.
- delay=3, num_pairs=2 -> antecedent @1 and @6; consequent @4 and @9; done @11; pairs_sent=2.
- delay=1, num_pairs=3, drop_consequent=1 -> antecedent @1, @4, @7; consequent never high; pairs_sent=3; done @10.
- delay=2, num_pairs=4; second start with delay=0 @cycle3; abort @cycle6 -> second start ignored; consequent @3 only; idle @7 with no done; pairs_sent=1.
- num_pairs=0 start -> busy stays 0; done pulses one cycle later; outputs stay low.
- rst_n low asynchronously mid-WAIT (delay=5) -> all outputs 0 before the next posedge; after release no pulses until start; then a normal run with pairs_sent restarting from 0.

Source files
------------

// File: rtl/implication_sequencer.sv
// Sequencer for antecedent/consequent stimulus pairs feeding implication-property checkers.
// Outputs are registered copies of the next-state decode, so nothing passes combinationally from inputs to outputs.
module implication_sequencer #(
    parameter int DELAY_W = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DELAY_W-1:0] delay,
    input  logic [COUNT_W-1:0] num_pairs,
    input  logic               drop_consequent,
    output logic               antecedent,
    output logic               consequent,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pairs_sent
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ANTE = 3'd1,
        S_WAIT = 3'd2,
        S_CONS = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [DELAY_W-1:0] wait_q, wait_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] pairs_q, pairs_d;
    logic               drop_q, drop_d;
    logic               ante_q, ante_d;
    logic               cons_q, cons_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state, latched-field and output decode.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        wait_d  = wait_q;
        count_d = count_q;
        pairs_d = pairs_q;
        drop_d  = drop_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pairs_d = {COUNT_W{1'b0}};
                    if (num_pairs != {COUNT_W{1'b0}}) begin
                        delay_d = delay;
                        count_d = num_pairs;
                        drop_d  = drop_consequent;
                        state_d = S_ANTE;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ANTE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (delay_q == {DELAY_W{1'b0}}) begin
                    pairs_d = pairs_q + COUNT_W'(1);
                    state_d = S_GAP;
                end else if (delay_q == DELAY_W'(1)) begin
                    state_d = S_CONS;
                end else begin
                    wait_d  = delay_q - DELAY_W'(2);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (wait_q == {DELAY_W{1'b0}}) begin
                    state_d = S_CONS;
                end else begin
                    wait_d = wait_q - DELAY_W'(1);
                end
            end
            S_CONS: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    pairs_d = pairs_q + COUNT_W'(1);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pairs_q == count_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ANTE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Delay 0 overlaps the consequent with the antecedent.
        ante_d = (state_d == S_ANTE);
        cons_d = !drop_d && (((state_d == S_ANTE) && (delay_d == {DELAY_W{1'b0}})) ||
                             (state_d == S_CONS));
        busy_d = (state_d != S_IDLE);
    end

    // State, latched fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            delay_q <= {DELAY_W{1'b0}};
            wait_q  <= {DELAY_W{1'b0}};
            count_q <= {COUNT_W{1'b0}};
            pairs_q <= {COUNT_W{1'b0}};
            drop_q  <= 1'b0;
            ante_q  <= 1'b0;
            cons_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            pairs_q <= pairs_d;
            drop_q  <= drop_d;
            ante_q  <= ante_d;
            cons_q  <= cons_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign antecedent = ante_q;
    assign consequent = cons_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pairs_sent = pairs_q;

endmodule

// File: tb/tb_implication_sequencer.sv
// Directed bench for implication_sequencer: per-cycle output traces compared against hand-computed bit masks.
`timescale 1ns/1ps
module tb_implication_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] delay = 4'd0;
    logic [7:0] num_pairs = 8'd0;
    logic       drop_consequent = 1'b0;
    logic       antecedent, consequent, busy, done;
    logic [7:0] pairs_sent;

    int total = 0;
    int bad = 0;
    logic [63:0] ante_v, cons_v, busy_v, done_v;

    implication_sequencer #(.DELAY_W(4), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .delay(delay),
        .num_pairs(num_pairs), .drop_consequent(drop_consequent),
        .antecedent(antecedent), .consequent(consequent), .busy(busy),
        .done(done), .pairs_sent(pairs_sent)
    );

    always #5 clk = ~clk;

    // Records outputs for cycles 1..ncyc; bit c of each trace is cycle c (start sampled at cycle 0).
    task automatic capture(input int ncyc, input int abort_at, input int restart_at);
        ante_v = 64'd0; cons_v = 64'd0; busy_v = 64'd0; done_v = 64'd0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            ante_v[c] = antecedent;
            cons_v[c] = consequent;
            busy_v[c] = busy;
            done_v[c] = done;
            start = (c == restart_at);
            if (c == restart_at) delay = 4'd0;
            abort = (c == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if ({antecedent, consequent, busy, done} !== 4'b0000) begin bad++; $display("FAIL reset_outs got=%b exp=0000", {antecedent, consequent, busy, done}); end
        total++; if (pairs_sent !== 8'd0) begin bad++; $display("FAIL reset_pairs got=%0d exp=0", pairs_sent); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        capture(3, -1, -1);
        total++; if ((ante_v | cons_v | busy_v | done_v) !== 64'd0) begin bad++; $display("FAIL reset_idle got=%h exp=0", ante_v | cons_v | busy_v | done_v); end
    endtask

    task automatic test_overlap();
        delay = 4'd0; num_pairs = 8'd1; drop_consequent = 1'b0; start = 1'b1;
        capture(5, -1, -1);
        total++; if (ante_v !== 64'h2) begin bad++; $display("FAIL ovl_ante got=%h exp=2", ante_v); end
        total++; if (cons_v !== 64'h2) begin bad++; $display("FAIL ovl_cons got=%h exp=2", cons_v); end
        total++; if (busy_v !== 64'h6) begin bad++; $display("FAIL ovl_busy got=%h exp=6", busy_v); end
        total++; if (done_v !== 64'h8) begin bad++; $display("FAIL ovl_done got=%h exp=8", done_v); end
        total++; if (pairs_sent !== 8'd1) begin bad++; $display("FAIL ovl_pairs got=%0d exp=1", pairs_sent); end
    endtask

    task automatic test_delay3();
        delay = 4'd3; num_pairs = 8'd2; drop_consequent = 1'b0; start = 1'b1;
        capture(13, -1, -1);
        total++; if (ante_v !== 64'h42) begin bad++; $display("FAIL d3_ante got=%h exp=42", ante_v); end
        total++; if (cons_v !== 64'h210) begin bad++; $display("FAIL d3_cons got=%h exp=210", cons_v); end
        total++; if (busy_v !== 64'h7FE) begin bad++; $display("FAIL d3_busy got=%h exp=7fe", busy_v); end
        total++; if (done_v !== 64'h800) begin bad++; $display("FAIL d3_done got=%h exp=800", done_v); end
        total++; if (pairs_sent !== 8'd2) begin bad++; $display("FAIL d3_pairs got=%0d exp=2", pairs_sent); end
    endtask

    task automatic test_drop();
        delay = 4'd1; num_pairs = 8'd3; drop_consequent = 1'b1; start = 1'b1;
        capture(12, -1, -1);
        drop_consequent = 1'b0;
        total++; if (ante_v !== 64'h92) begin bad++; $display("FAIL drop_ante got=%h exp=92", ante_v); end
        total++; if (cons_v !== 64'h0) begin bad++; $display("FAIL drop_cons got=%h exp=0", cons_v); end
        total++; if (busy_v !== 64'h3FE) begin bad++; $display("FAIL drop_busy got=%h exp=3fe", busy_v); end
        total++; if (done_v !== 64'h400) begin bad++; $display("FAIL drop_done got=%h exp=400", done_v); end
        total++; if (pairs_sent !== 8'd3) begin bad++; $display("FAIL drop_pairs got=%0d exp=3", pairs_sent); end
    endtask

    task automatic test_abort();
        delay = 4'd2; num_pairs = 8'd4; start = 1'b1;
        capture(10, 6, 3);
        total++; if (ante_v !== 64'h22) begin bad++; $display("FAIL abort_ante got=%h exp=22", ante_v); end
        total++; if (cons_v !== 64'h8) begin bad++; $display("FAIL abort_cons got=%h exp=8", cons_v); end
        total++; if (busy_v !== 64'h7E) begin bad++; $display("FAIL abort_busy got=%h exp=7e", busy_v); end
        total++; if (done_v !== 64'h0) begin bad++; $display("FAIL abort_done got=%h exp=0", done_v); end
        total++; if (pairs_sent !== 8'd1) begin bad++; $display("FAIL abort_pairs got=%0d exp=1", pairs_sent); end
    endtask

    task automatic test_zero_pairs();
        delay = 4'd3; num_pairs = 8'd0; start = 1'b1;
        capture(4, -1, -1);
        total++; if ((ante_v | cons_v | busy_v) !== 64'h0) begin bad++; $display("FAIL zero_act got=%h exp=0", ante_v | cons_v | busy_v); end
        total++; if (done_v !== 64'h2) begin bad++; $display("FAIL zero_done got=%h exp=2", done_v); end
        total++; if (pairs_sent !== 8'd0) begin bad++; $display("FAIL zero_pairs got=%0d exp=0", pairs_sent); end
    endtask

    task automatic test_start_abort_idle();
        delay = 4'd1; num_pairs = 8'd1; start = 1'b1; abort = 1'b1;
        capture(6, -1, -1);
        total++; if (ante_v !== 64'h2) begin bad++; $display("FAIL sa_ante got=%h exp=2", ante_v); end
        total++; if (cons_v !== 64'h4) begin bad++; $display("FAIL sa_cons got=%h exp=4", cons_v); end
        total++; if (done_v !== 64'h10) begin bad++; $display("FAIL sa_done got=%h exp=10", done_v); end
    endtask

    task automatic test_max_delay();
        delay = 4'd15; num_pairs = 8'd1; start = 1'b1;
        capture(20, -1, -1);
        total++; if (ante_v !== 64'h2) begin bad++; $display("FAIL dmax_ante got=%h exp=2", ante_v); end
        total++; if (cons_v !== 64'h10000) begin bad++; $display("FAIL dmax_cons got=%h exp=10000", cons_v); end
        total++; if (done_v !== 64'h40000) begin bad++; $display("FAIL dmax_done got=%h exp=40000", done_v); end
    endtask

    task automatic test_async_reset();
        delay = 4'd5; num_pairs = 8'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++; if ({antecedent, consequent, busy, done} !== 4'b0000) begin bad++; $display("FAIL arst_outs got=%b exp=0000", {antecedent, consequent, busy, done}); end
        total++; if (pairs_sent !== 8'd0) begin bad++; $display("FAIL arst_pairs got=%0d exp=0", pairs_sent); end
        @(negedge clk); rst_n = 1'b1;
        capture(8, -1, -1);
        total++; if ((ante_v | cons_v | busy_v | done_v) !== 64'h0) begin bad++; $display("FAIL arst_quiet got=%h exp=0", ante_v | cons_v | busy_v | done_v); end
        delay = 4'd0; num_pairs = 8'd2; start = 1'b1;
        capture(7, -1, -1);
        total++; if (ante_v !== 64'hA) begin bad++; $display("FAIL arst_ante got=%h exp=a", ante_v); end
        total++; if (done_v !== 64'h20) begin bad++; $display("FAIL arst_done got=%h exp=20", done_v); end
        total++; if (pairs_sent !== 8'd2) begin bad++; $display("FAIL arst_pairs2 got=%0d exp=2", pairs_sent); end
    endtask

    task automatic test_max_count();
        int c;
        c = 0;
        delay = 4'd0; num_pairs = 8'd255; start = 1'b1;
        while (c < 600) begin
            @(posedge clk); #1;
            start = 1'b0;
            c++;
            if (done) break;
        end
        total++; if (c !== 511) begin bad++; $display("FAIL maxn_cycles got=%0d exp=511", c); end
        total++; if (pairs_sent !== 8'd255) begin bad++; $display("FAIL maxn_pairs got=%0d exp=255", pairs_sent); end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_delay3();
        test_drop();
        test_abort();
        test_zero_pairs();
        test_start_abort_idle();
        test_max_delay();
        test_async_reset();
        test_max_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
